// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits (LSB first),
// optional parity and 1-2 stop bits. Define UART_TX_FIFO_EN to add an input FIFO.
module uart_tx_param #(
  parameter int CLK_DIV     = 1250,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_AW     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
    $error("uart_tx_param: CLK_DIV must be in 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_AW < 1 || FIFO_AW > 16) begin : g_bad_fifo_aw
    $error("uart_tx_param: FIFO_AW must be in 1..16");
  end

  localparam int              CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [3:0]           bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_reg, par_next;
  logic                 tx_reg, tx_next;
  logic                 done_reg, done_next;
  logic                 busy_reg, busy_next;
  logic                 bit_end;
  logic                 load;

  // Word source seen by the shifter; differs between FIFO and direct builds
  logic [DATA_BITS-1:0] src_data;
  logic                 idle_avail;
  logic                 pend_avail;
  logic                 pend_next;

`ifdef UART_TX_FIFO_EN
  localparam int               DEPTH    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] FCNT_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  logic [DATA_BITS-1:0] fifo_mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]     fifo_cnt_reg, fifo_cnt_next;
  logic                 fifo_empty, fifo_full, bypass, push, pop;

  assign fifo_empty = (fifo_cnt_reg == '0);
  assign fifo_full  = (fifo_cnt_reg == FULL_CNT);
  assign tx_ready   = !fifo_full;
  // An idle shifter with nothing queued takes the word straight from the port
  assign bypass     = (state_reg == S_IDLE) && fifo_empty;
  assign push       = tx_valid && tx_ready && !bypass;
  assign pop        = load && !fifo_empty;
  assign src_data   = fifo_empty ? tx_data : fifo_mem[rd_ptr_reg];
  assign idle_avail = !fifo_empty || tx_valid;
  assign pend_avail = !fifo_empty;
  assign pend_next  = (fifo_cnt_next != '0);

  always_comb begin
    fifo_cnt_next = fifo_cnt_reg;
    if (push && !pop) begin
      fifo_cnt_next = fifo_cnt_reg + FCNT_ONE;
    end else if (pop && !push) begin
      fifo_cnt_next = fifo_cnt_reg - FCNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      fifo_cnt_reg <= fifo_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= tx_data;
  end
`else
  assign tx_ready   = (state_reg == S_IDLE);
  assign src_data   = tx_data;
  assign idle_avail = tx_valid;
  assign pend_avail = 1'b0;
  assign pend_next  = 1'b0;
`endif

  assign bit_end = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    load       = 1'b0;

    if (state_reg != S_IDLE) begin
      cnt_next = bit_end ? '0 : cnt_reg + CNT_ONE;
    end

    case (state_reg)
      S_IDLE: begin
        if (idle_avail) begin
          load       = 1'b1;
          state_next = S_START;
          cnt_next   = '0;
          bit_next   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_next = S_DATA;
          bit_next   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_reg == DATA_LAST) begin
            bit_next   = '0;
            state_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_next = bit_reg + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_next = S_STOP;
          bit_next   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_reg == STOP_LAST) begin
            bit_next = '0;
            // A queued word starts on the very next cycle: no idle gap
            if (pend_avail) begin
              load       = 1'b1;
              state_next = S_START;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            bit_next = bit_reg + 4'd1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
        bit_next   = '0;
      end
    endcase

    if (load) begin
      shift_next = src_data;
      par_next   = (PARITY_MODE == 1) ? ~(^src_data) : (^src_data);
    end

    // Outputs are registered from the next-state view so they line up with it
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
      S_PARITY: tx_next = par_next;
      default:  tx_next = 1'b1;
    endcase

    done_next = (state_next == S_STOP) && (cnt_next == CNT_LAST) &&
                (bit_next == STOP_LAST);
    busy_next = (state_next != S_IDLE) || pend_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
    end
  end

  assign tx   = tx_reg;
  assign done = done_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances (8N1/4, 7E2/4, 8O1/3) checked every
// cycle against a frame-level model; handles both FIFO and direct builds.
module tb_uart_tx_param;

  localparam int DIV_A [3] = '{4, 4, 3};
  localparam int DB_A  [3] = '{8, 7, 8};
  localparam int PM_A  [3] = '{0, 2, 1};
  localparam int SB_A  [3] = '{1, 2, 1};
  localparam int A5_EXP [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`ifdef UART_TX_FIFO_EN
  localparam int QDEPTH = 4;
`else
  localparam int QDEPTH = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] tv;
  logic [7:0] td0;
  logic [6:0] td1;
  logic [7:0] td2;
  wire  [2:0] rdy, txo, bsy, dn;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tv[0]), .tx_ready(rdy[0]), .tx_data(td0),
    .tx(txo[0]), .busy(bsy[0]), .done(dn[0]));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tv[1]), .tx_ready(rdy[1]), .tx_data(td1),
    .tx(txo[1]), .busy(bsy[1]), .done(dn[1]));
  uart_tx_param #(.CLK_DIV(3), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tv[2]), .tx_ready(rdy[2]), .tx_data(td2),
    .tx(txo[2]), .busy(bsy[2]), .done(dn[2]));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int frame_len(input int i);
    return DIV_A[i] * (1 + DB_A[i] + ((PM_A[i] != 0) ? 1 : 0) + SB_A[i]);
  endfunction

  // Value of bit slot idx of the frame carrying word w on instance i
  function automatic int frame_bit(input int i, input logic [8:0] w, input int idx);
    int ones;
    if (idx == 0) return 0;
    if (idx <= DB_A[i]) return int'(w[idx-1]);
    if (PM_A[i] != 0 && idx == DB_A[i] + 1) begin
      ones = $countones(w);
      if (PM_A[i] == 1) return (ones % 2 == 0) ? 1 : 0;
      return ones % 2;
    end
    return 1;
  endfunction

  function automatic logic [8:0] data_of(input int i);
    case (i)
      0:       return {1'b0, td0};
      1:       return {2'b0, td1};
      default: return {1'b0, td2};
    endcase
  endfunction

  // Model state: active frame, cycle offset into it, its word, pending queue
  bit         mvalid = 1'b0;
  bit         act [3];
  int         kk  [3];
  logic [8:0] wrd [3];
  logic [8:0] qd  [3][8];
  int         qn  [3];

  function automatic bit exp_ready(input int i);
    if (QDEPTH > 0) return qn[i] < QDEPTH;
    return !act[i];
  endfunction

  initial begin : model
    logic [8:0] dw;
    bit acc, taken;
    forever begin
      @(negedge clk);
      if (mvalid) begin
        for (int i = 0; i < 3; i++) begin
          int etx, edn, ebs;
          if (act[i]) begin
            etx = frame_bit(i, wrd[i], kk[i] / DIV_A[i]);
            edn = (kk[i] == frame_len(i) - 1) ? 1 : 0;
            ebs = 1;
          end else begin
            etx = 1;
            edn = 0;
            ebs = (qn[i] > 0) ? 1 : 0;
          end
          chk($sformatf("tx%0d", i),    int'(txo[i]), etx);
          chk($sformatf("done%0d", i),  int'(dn[i]),  edn);
          chk($sformatf("busy%0d", i),  int'(bsy[i]), ebs);
          chk($sformatf("ready%0d", i), int'(rdy[i]), int'(exp_ready(i)));
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          act[i] = 1'b0;
          kk[i]  = 0;
          qn[i]  = 0;
        end else begin
          dw    = data_of(i);
          acc   = tv[i] && exp_ready(i);
          taken = 1'b0;
          if (act[i]) begin
            if (kk[i] == frame_len(i) - 1) begin
              if (qn[i] > 0) begin
                wrd[i] = qd[i][0];
                for (int j = 0; j < 7; j++) qd[i][j] = qd[i][j+1];
                qn[i]--;
                kk[i] = 0;
              end else begin
                act[i] = 1'b0;
              end
            end else begin
              kk[i]++;
            end
          end else if (qn[i] > 0) begin
            wrd[i] = qd[i][0];
            for (int j = 0; j < 7; j++) qd[i][j] = qd[i][j+1];
            qn[i]--;
            act[i] = 1'b1;
            kk[i]  = 0;
          end else if (acc) begin
            wrd[i] = dw;
            act[i] = 1'b1;
            kk[i]  = 0;
            taken  = 1'b1;
          end
          if (acc && !taken) begin
            qd[i][qn[i]] = dw;
            qn[i]++;
          end
          if (acc) $display("accept dut%0d data=%03h t=%0t", i, dw, $time);
        end
      end
      if (!rst_n) mvalid = 1'b1;
    end
  end

  // Watch one round of directed frames; c counts cycles after the accept edge
  task automatic watch(input bit round1, input int p1_exp, input int p2_exp);
    int fd [3];
    int p1, p2, rdy_hi;
    logic [9:0] a5_bits;
    fd = '{0, 0, 0};
    p1 = -1;
    p2 = -1;
    rdy_hi = 0;
    a5_bits = '0;
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (dn[i] && fd[i] == 0) fd[i] = c;
      if (c >= 2 && c <= 38 && (c - 2) % 4 == 0) a5_bits[(c-2)/4] = txo[0];
      if (c <= 40 && rdy[0]) rdy_hi = 1;
      if (c == 34) p1 = int'(txo[1]);
      if (c == 29) p2 = int'(txo[2]);
    end
    if (round1) begin
      for (int j = 0; j < 10; j++) chk($sformatf("a5_bit%0d", j), int'(a5_bits[j]), A5_EXP[j]);
      chk("a5_done_cycle", fd[0], 40);
      chk("a5_ready_low", rdy_hi, 0);
    end
    chk("7e2_done_cycle", fd[1], 44);
    chk("8o1_done_cycle", fd[2], 33);
    chk("7e2_parity", p1, p1_exp);
    chk("8o1_parity", p2, p2_exp);
  endtask

  initial begin : stim
    int cnt;
    rst_n = 1'b0;
    tv    = '0;
    td0   = '0;
    td1   = '0;
    td2   = '0;

    // Pin the model against hand-computed values
    for (int j = 0; j < 10; j++) chk($sformatf("model_a5_bit%0d", j), frame_bit(0, 9'h0A5, j), A5_EXP[j]);
    chk("model_len_8n1", frame_len(0), 40);
    chk("model_len_7e2", frame_len(1), 44);
    chk("model_len_8o1", frame_len(2), 33);
    chk("model_par_35", frame_bit(1, 9'h035, 8), 0);
    chk("model_par_34", frame_bit(1, 9'h034, 8), 1);
    chk("model_par_00", frame_bit(2, 9'h000, 9), 1);
    chk("model_par_ff", frame_bit(2, 9'h0FF, 9), 1);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx", int'(txo), 7);
    chk("rst_ready", int'(rdy), 7);
    chk("rst_busy", int'(bsy), 0);
    chk("rst_done", int'(dn), 0);

    // Directed frames: A5 on 8N1, 35 on 7E2, 00 on 8O1, then 34 and FF
    @(posedge clk);
    #1 tv = 3'b111; td0 = 8'hA5; td1 = 7'h35; td2 = 8'h00;
    @(posedge clk);
    #1 tv = '0;
    watch(1'b1, 0, 1);
    @(posedge clk);
    #1 tv = 3'b110; td1 = 7'h34; td2 = 8'hFF;
    @(posedge clk);
    #1 tv = '0;
    watch(1'b0, 1, 1);

    // tx_valid held high: three frames inside 123 cycles, one accept each
    @(posedge clk);
    #1 tv[0] = 1'b1; td0 = 8'h3C;
    @(posedge clk);
    cnt = 0;
    for (int c = 1; c <= 123; c++) begin
      @(negedge clk);
      if (dn[0]) cnt++;
    end
    chk("held_valid_frames", cnt, 3);
    @(posedge clk);
    #1 tv = '0;
    repeat (250) @(posedge clk);

    // Reset in the middle of a frame
    #1 tv = 3'b111; td0 = 8'h5A; td1 = 7'h2B; td2 = 8'hC3;
    @(posedge clk);
    #1 tv = '0;
    repeat (14) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_tx", int'(txo), 7);
    chk("midrst_busy", int'(bsy), 0);
    chk("midrst_ready", int'(rdy), 7);
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      if (dn != 3'b000) cnt++;
      @(negedge clk);
    end
    chk("midrst_no_done", cnt, 0);

    // Random traffic with rare resets
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 599) != 0);
      tv    = 3'($urandom);
      td0   = 8'($urandom);
      td1   = 7'($urandom);
      td2   = 8'($urandom);
    end
    @(posedge clk);
    #1 rst_n = 1'b1; tv = '0;
    repeat (300) @(posedge clk);
    @(negedge clk);
    chk("drain_busy", int'(bsy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
